// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: FSM state type and length-mask helper
// shared by the serial pattern detector files.
package seq_detector_pkg;

   localparam int unsigned MAX_PAT_W = 64;
   localparam int unsigned LEN_W = $clog2(MAX_PAT_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HUNT = 2'd2
   } state_e;

   // Ones in the low 'len' positions; callers cast to their own width.
   function automatic logic [MAX_PAT_W-1:0] len_mask(
      input int unsigned len
   );
      logic [MAX_PAT_W-1:0] m;
      if (len >= MAX_PAT_W) m = '1;
      else m = ~({MAX_PAT_W{1'b1}} << len);
      return m;
   endfunction

endpackage

// File: rtl/seq_detector_sat_cnt.sv
// seq_detector_sat_cnt: W-bit counter that stops at all-ones
// and clears synchronously on clr_i.
module seq_detector_sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// seq_detector: run-time configurable serial pattern detector.
// Define SEQ_DETECTOR_MASK_EN to add the cfg_mask_i don't-care mask.
module seq_detector
   import seq_detector_pkg::*;
#(
   parameter int unsigned          PATTERN_W   = 8,
   parameter int unsigned          CNT_W       = 16,
   parameter logic [PATTERN_W-1:0] RST_PATTERN = PATTERN_W'(8'b0000_0011),
   parameter int unsigned          RST_LEN     = 2,
   parameter logic                 RST_OVERLAP = 1'b1
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             enable_i,
   input  logic                             valid_i,
   input  logic                             data_i,
   input  logic                             cfg_load_i,
   input  logic [PATTERN_W-1:0]             cfg_pattern_i,
   input  logic [$clog2(PATTERN_W+1)-1:0]   cfg_len_i,
   input  logic                             cfg_overlap_i,
`ifdef SEQ_DETECTOR_MASK_EN
   input  logic [PATTERN_W-1:0]             cfg_mask_i,
`endif
   output logic                             match_o,
   output logic [CNT_W-1:0]                 match_count_o,
   output logic [1:0]                       state_o
);

   localparam int unsigned LW = $clog2(PATTERN_W + 1);
   localparam logic [LW-1:0] PW_L = LW'(PATTERN_W);
   localparam logic [LW-1:0] RST_LEN_L = LW'(RST_LEN);

   state_e               state_q;
   logic [PATTERN_W-2:0] hist_q;
   logic [PATTERN_W-1:0] pat_q;
   logic [PATTERN_W-1:0] mask_q;
   logic [PATTERN_W-1:0] cand;
   logic [PATTERN_W-1:0] lenmask;
   logic [LW-1:0]        len_q;
   logic [LW-1:0]        fill_q;
   logic [LW-1:0]        fill_d;
   logic [LW-1:0]        eff_len;
   logic [LW:0]          fill_p1;
   logic                 ov_q;
   logic                 match_q;
   logic                 full;
   logic                 accept;
   logic                 hit;

`ifndef SEQ_DETECTOR_MASK_EN
   assign mask_q = '1;
`endif

   always_comb begin
      eff_len = (len_q > PW_L) ? PW_L : len_q;
      lenmask = PATTERN_W'(len_mask(32'(eff_len)));
      cand    = {hist_q, data_i};
      fill_p1 = {1'b0, fill_q} + {{LW{1'b0}}, 1'b1};
      full    = (fill_p1 >= {1'b0, eff_len});
      fill_d  = full ? eff_len : fill_p1[LW-1:0];
      accept  = valid_i & enable_i & ~cfg_load_i
              & (state_q != IDLE) & (eff_len != '0);
      hit     = accept & full
              & (((cand ^ pat_q) & mask_q & lenmask) == '0);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= (RST_LEN_L != '0) ? FILL : IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         pat_q   <= RST_PATTERN;
         len_q   <= RST_LEN_L;
         ov_q    <= RST_OVERLAP;
`ifdef SEQ_DETECTOR_MASK_EN
         mask_q  <= '1;
`endif
      end else if (cfg_load_i) begin
         pat_q   <= cfg_pattern_i;
         len_q   <= cfg_len_i;
         ov_q    <= cfg_overlap_i;
`ifdef SEQ_DETECTOR_MASK_EN
         mask_q  <= cfg_mask_i;
`endif
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         state_q <= (cfg_len_i != '0) ? FILL : IDLE;
      end else if (!enable_i || (eff_len == '0)) begin
         state_q <= IDLE;
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         match_q <= hit;
         unique case (state_q)
            IDLE: state_q <= FILL;
            FILL, HUNT: begin
               if (accept) begin
                  hist_q <= cand[PATTERN_W-2:0];
                  // Non-overlap restarts the fill so no bit is reused.
                  if (hit && !ov_q) begin
                     fill_q  <= '0;
                     state_q <= FILL;
                  end else begin
                     fill_q <= fill_d;
                     if (full) state_q <= HUNT;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   seq_detector_sat_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (hit),
      .clr_i   (cfg_load_i),
      .cnt_o   (match_count_o)
   );

   assign match_o = match_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed scenarios for seq_detector, with a
// second CNT_W=2 instance for counter saturation.
module tb_seq_detector;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       valid = 1'b0;
   logic       data = 1'b0;
   logic       ld = 1'b0;
   logic       ov = 1'b0;
   logic [7:0] pat = '0;
   logic [7:0] mask = '1;
   logic [3:0] len = '0;

   logic        m1, m2;
   logic [15:0] c1;
   logic [1:0]  c2;
   logic [1:0]  s1, s2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_detector dut (
      .clk_i         (clk),
      .reset_i       (rst_n),
      .enable_i      (en),
      .valid_i       (valid),
      .data_i        (data),
      .cfg_load_i    (ld),
      .cfg_pattern_i (pat),
      .cfg_len_i     (len),
      .cfg_overlap_i (ov),
`ifdef SEQ_DETECTOR_MASK_EN
      .cfg_mask_i    (mask),
`endif
      .match_o       (m1),
      .match_count_o (c1),
      .state_o       (s1)
   );

   seq_detector #(.CNT_W(2)) dut2 (
      .clk_i         (clk),
      .reset_i       (rst_n),
      .enable_i      (en),
      .valid_i       (valid),
      .data_i        (data),
      .cfg_load_i    (ld),
      .cfg_pattern_i (pat),
      .cfg_len_i     (len),
      .cfg_overlap_i (ov),
`ifdef SEQ_DETECTOR_MASK_EN
      .cfg_mask_i    (mask),
`endif
      .match_o       (m2),
      .match_count_o (c2),
      .state_o       (s2)
   );

   task automatic step(input logic v, input logic d);
      valid = v;
      data  = d;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic [7:0] mk);
      pat  = p;
      len  = l;
      ov   = o;
      mask = mk;
      ld   = 1'b1;
      @(negedge clk);
      ld   = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (m1 !== 1'b0) begin
         errors++; $display("FAIL rst_match got=%b exp=0", m1);
      end
      checks++;
      if (c1 !== 16'd0) begin
         errors++; $display("FAIL rst_count got=%0d exp=0", c1);
      end
      checks++;
      if (s1 !== 2'd1 || s2 !== 2'd1) begin
         errors++; $display("FAIL rst_state got=%0d/%0d exp=1", s1, s2);
      end
      checks++;
      if (c2 !== 2'd0 || m2 !== 1'b0) begin
         errors++; $display("FAIL rst_dut2 got=%0d/%b exp=0/0", c2, m2);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_default_pattern;
      logic b[6] = '{1, 1, 1, 0, 1, 1};
      logic e[6] = '{0, 1, 1, 0, 0, 1};
      for (int i = 0; i < 6; i++) begin
         step(1'b1, b[i]);
         checks++;
         if (m1 !== e[i]) begin
            errors++; $display("FAIL dflt_bit%0d got=%b exp=%b", i, m1, e[i]);
         end
      end
      checks++;
      if (c1 !== 16'd3) begin
         errors++; $display("FAIL dflt_count got=%0d exp=3", c1);
      end
   endtask

   task automatic test_overlap_modes;
      logic b[5]  = '{1, 0, 1, 0, 1};
      logic e0[5] = '{0, 0, 1, 0, 0};
      logic e1[5] = '{0, 0, 1, 0, 1};
      load(8'b101, 4'd3, 1'b0, 8'hFF);
      checks++;
      if (s1 !== 2'd1 || c1 !== 16'd0) begin
         errors++; $display("FAIL load_state got=%0d/%0d exp=1/0", s1, c1);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, b[i]);
         checks++;
         if (m1 !== e0[i]) begin
            errors++; $display("FAIL novl_bit%0d got=%b exp=%b", i, m1, e0[i]);
         end
      end
      checks++;
      if (c1 !== 16'd1) begin
         errors++; $display("FAIL novl_count got=%0d exp=1", c1);
      end
      load(8'b101, 4'd3, 1'b1, 8'hFF);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, b[i]);
         checks++;
         if (m1 !== e1[i]) begin
            errors++; $display("FAIL ovl_bit%0d got=%b exp=%b", i, m1, e1[i]);
         end
      end
      checks++;
      if (c1 !== 16'd2 || s1 !== 2'd2) begin
         errors++; $display("FAIL ovl_end got=%0d/%0d exp=2/2", c1, s1);
      end
   endtask

   task automatic test_gaps;
      logic b[3] = '{1, 0, 1};
      load(8'b101, 4'd3, 1'b1, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, b[i]);
         checks++;
         if (m1 !== (i == 2)) begin
            errors++; $display("FAIL gap_bit%0d got=%b exp=%b", i, m1, i == 2);
         end
         for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b1);
            checks++;
            if (m1 !== 1'b0) begin
               errors++; $display("FAIL gap_idle%0d_%0d got=%b exp=0", i, g, m1);
            end
         end
      end
      checks++;
      if (c1 !== 16'd1) begin
         errors++; $display("FAIL gap_count got=%0d exp=1", c1);
      end
   endtask

   task automatic test_saturation;
      load(8'b11, 4'd2, 1'b1, 8'hFF);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
      checks++;
      if (c2 !== 2'd3 || m2 !== 1'b1) begin
         errors++; $display("FAIL sat_cnt2 got=%0d/%b exp=3/1", c2, m2);
      end
      checks++;
      if (c1 !== 16'd6) begin
         errors++; $display("FAIL sat_cnt16 got=%0d exp=6", c1);
      end
   endtask

   task automatic test_load_collision;
      logic e[4] = '{0, 0, 0, 1};
      load(8'b1111, 4'd4, 1'b1, 8'hFF);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      pat   = 8'b0000;
      len   = 4'd4;
      ld    = 1'b1;
      valid = 1'b1;
      data  = 1'b1;
      @(negedge clk);
      ld    = 1'b0;
      valid = 1'b0;
      checks++;
      if (m1 !== 1'b0 || c1 !== 16'd0 || s1 !== 2'd1) begin
         errors++;
         $display("FAIL coll_load got=%b/%0d/%0d exp=0/0/1", m1, c1, s1);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0);
         checks++;
         if (m1 !== e[i]) begin
            errors++; $display("FAIL coll_bit%0d got=%b exp=%b", i, m1, e[i]);
         end
      end
   endtask

   task automatic test_enable_drop;
      load(8'b11, 4'd2, 1'b1, 8'hFF);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      en = 1'b0;
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      checks++;
      if (s1 !== 2'd0 || m1 !== 1'b0 || c1 !== 16'd1) begin
         errors++;
         $display("FAIL en_off got=%0d/%b/%0d exp=0/0/1", s1, m1, c1);
      end
      en = 1'b1;
      step(1'b0, 1'b0);
      checks++;
      if (s1 !== 2'd1) begin
         errors++; $display("FAIL en_on_state got=%0d exp=1", s1);
      end
      step(1'b1, 1'b1);
      checks++;
      if (m1 !== 1'b0) begin
         errors++; $display("FAIL en_refill got=%b exp=0", m1);
      end
      step(1'b1, 1'b1);
      checks++;
      if (m1 !== 1'b1 || c1 !== 16'd2) begin
         errors++; $display("FAIL en_match got=%b/%0d exp=1/2", m1, c1);
      end
   endtask

   task automatic test_lengths;
      load(8'h00, 4'd0, 1'b1, 8'hFF);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      checks++;
      if (s1 !== 2'd0 || m1 !== 1'b0 || c1 !== 16'd0) begin
         errors++;
         $display("FAIL len0 got=%0d/%b/%0d exp=0/0/0", s1, m1, c1);
      end
      load(8'hFF, 4'd9, 1'b1, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1);
         checks++;
         if (m1 !== (i == 7)) begin
            errors++; $display("FAIL clamp_bit%0d got=%b exp=%b", i, m1, i == 7);
         end
      end
   endtask

`ifdef SEQ_DETECTOR_MASK_EN
   task automatic test_mask;
      load(8'b101, 4'd3, 1'b1, 8'b101);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1);
         checks++;
         if (m1 !== (i == 2)) begin
            errors++; $display("FAIL mask_bit%0d got=%b exp=%b", i, m1, i == 2);
         end
      end
   endtask
`endif

   task automatic test_reset_midstream;
      load(8'b101, 4'd3, 1'b1, 8'hFF);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      checks++;
      if (m1 !== 1'b1) begin
         errors++; $display("FAIL mid_pulse got=%b exp=1", m1);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (m1 !== 1'b0 || c1 !== 16'd0 || s1 !== 2'd1) begin
         errors++;
         $display("FAIL mid_rst got=%b/%0d/%0d exp=0/0/1", m1, c1, s1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1);
      checks++;
      if (m1 !== 1'b0 || c1 !== 16'd0) begin
         errors++; $display("FAIL mid_after got=%b/%0d exp=0/0", m1, c1);
      end
   endtask

   initial begin
      test_reset();
      test_default_pattern();
      test_overlap_modes();
      test_gaps();
      test_saturation();
      test_load_collision();
      test_enable_drop();
      test_lengths();
`ifdef SEQ_DETECTOR_MASK_EN
      test_mask();
`endif
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
